// File: rtl/m72_pkg.sv
// Shared types for the M72 interrupt controller: register map, FSM states
// and the vector width seen by the V30 core.
package m72_pkg;

  typedef enum logic [1:0] {
    IRQ_REG_MASK  = 2'd0,
    IRQ_REG_MODE  = 2'd1,
    IRQ_REG_VBASE = 2'd2,
    IRQ_REG_EOI   = 2'd3
  } irq_reg_t;

  typedef enum logic {
    IRQ_IDLE = 1'b0,
    IRQ_REQ  = 1'b1
  } irq_state_t;

  localparam int IRQ_VEC_W = 9;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set encoder: bit 0 has the highest priority.
module irq_prio_enc #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    valid = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl_multi.sv
// N-channel vectored interrupt controller for the V30 core: per-channel mask,
// edge/level mode, programmable vector base, fixed priority, optional EOI.
module irq_ctrl_multi
  import m72_pkg::*;
#(
  parameter int         N_IRQ      = 2,
  parameter int         VEC_STRIDE = 8,
  parameter int         AUTO_EOI   = 1,
  parameter logic [7:0] MASK_RST   = 8'h00,
  parameter logic [7:0] MODE_RST   = 8'h00,
  parameter logic [7:0] VBASE_RST  = 8'h40
) (
  input  logic                 CLK_32M,
  input  logic                 reset_n,
  input  logic                 ce,
  input  logic [N_IRQ-1:0]     irq_in,
  input  logic                 cfg_we,
  input  logic                 cfg_re,
  input  logic [1:0]           cfg_addr,
  input  logic [7:0]           cfg_din,
  output logic [7:0]           cfg_dout,
  output logic                 irq_rq,
  output logic [IRQ_VEC_W-1:0] irq_vector,
  input  logic                 irq_ack
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_t           state_q, state_nxt;
  logic [N_IRQ-1:0]     mask_q, mode_q, pend_q, pend_nxt, prev_q, ins_q, ins_nxt;
  logic [N_IRQ-1:0]     eligible;
  logic [7:0]           vbase_q;
  logic [IDX_W-1:0]     grant_q, grant_nxt, win_idx, eoi_idx;
  logic [IRQ_VEC_W-1:0] vec_q, vec_nxt;
  logic                 win_valid, eoi_valid, ack_fire, eoi_wr, blocked;
  logic                 unused_cfg_re;

  assign unused_cfg_re = cfg_re;
  assign ack_fire      = irq_ack && (state_q == IRQ_REQ);
  assign eoi_wr        = cfg_we && (irq_reg_t'(cfg_addr) == IRQ_REG_EOI);

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      mask_q  <= MASK_RST[N_IRQ-1:0];
      mode_q  <= MODE_RST[N_IRQ-1:0];
      vbase_q <= VBASE_RST;
    end else if (cfg_we) begin
      case (irq_reg_t'(cfg_addr))
        IRQ_REG_MASK:  mask_q  <= cfg_din[N_IRQ-1:0];
        IRQ_REG_MODE:  mode_q  <= cfg_din[N_IRQ-1:0];
        IRQ_REG_VBASE: vbase_q <= cfg_din;
        default:       ;
      endcase
    end
  end

  always_comb begin
    cfg_dout = '0;
    case (irq_reg_t'(cfg_addr))
      IRQ_REG_MASK:  cfg_dout[N_IRQ-1:0] = mask_q;
      IRQ_REG_MODE:  cfg_dout[N_IRQ-1:0] = mode_q;
      IRQ_REG_VBASE: cfg_dout            = vbase_q;
      default:       cfg_dout[N_IRQ-1:0] = pend_q;
    endcase
  end

  // A channel is blocked by its own or any higher-priority in-service bit.
  always_comb begin
    blocked  = 1'b0;
    eligible = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      blocked     = blocked | ins_q[i];
      eligible[i] = pend_q[i] & ~mask_q[i] & ((AUTO_EOI != 0) | ~blocked);
    end
  end

  irq_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_win (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  irq_prio_enc #(.N(N_IRQ), .IDX_W(IDX_W)) u_eoi (
    .req   (ins_q),
    .valid (eoi_valid),
    .idx   (eoi_idx)
  );

  // Ack clears first so a fresh edge sampled in the same cycle survives.
  always_comb begin
    pend_nxt = pend_q;
    if (ack_fire && !mode_q[grant_q]) pend_nxt[grant_q] = 1'b0;
    if (ce) begin
      for (int i = 0; i < N_IRQ; i++) begin
        if (mode_q[i])                 pend_nxt[i] = irq_in[i];
        else if (irq_in[i] & ~prev_q[i]) pend_nxt[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ins_nxt = ins_q;
    if (AUTO_EOI == 0) begin
      if (eoi_wr && eoi_valid) ins_nxt[eoi_idx] = 1'b0;
      if (ack_fire)            ins_nxt[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      prev_q <= '0;
      ins_q  <= '0;
    end else begin
      pend_q <= pend_nxt;
      ins_q  <= ins_nxt;
      if (ce) prev_q <= irq_in;
    end
  end

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    vec_nxt   = vec_q;
    case (state_q)
      IRQ_IDLE: begin
        if (ce && win_valid) begin
          state_nxt = IRQ_REQ;
          grant_nxt = win_idx;
          vec_nxt   = {vbase_q, 1'b0} + IRQ_VEC_W'(int'(win_idx) * VEC_STRIDE);
        end
      end
      IRQ_REQ: begin
        if (irq_ack) state_nxt = IRQ_IDLE;
      end
      default: state_nxt = IRQ_IDLE;
    endcase
  end

  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IRQ_IDLE;
      grant_q <= '0;
      vec_q   <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      vec_q   <= vec_nxt;
    end
  end

  assign irq_rq     = (state_q == IRQ_REQ);
  assign irq_vector = vec_q;

endmodule

// File: tb/tb_irq_ctrl_multi.sv
// Bench for irq_ctrl_multi: a default 2-channel auto-EOI instance and a
// 4-channel instance with in-service tracking, both checked against a model.
module tb_irq_ctrl_multi;

  logic       CLK_32M = 1'b0;
  logic       reset_n, ce;
  logic [1:0] irq_a, addr_a;
  logic [3:0] irq_b;
  logic [1:0] addr_b;
  logic       we_a, we_b, re_a, re_b, ack_a, ack_b, rq_a, rq_b;
  logic [7:0] din_a, din_b, dout_a, dout_b;
  logic [8:0] vec_a, vec_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state, index 0 = instance a, 1 = instance b
  localparam int NCH[2]  = '{2, 4};
  localparam bit AUTO[2] = '{1'b1, 1'b0};
  localparam int STRIDE  = 8;
  bit [7:0] m_mask[2], m_mode[2], m_vbase[2], m_pend[2], m_prev[2], m_ins[2];
  bit       m_req[2];
  int       m_grant[2], m_vec[2];

  typedef struct {
    int         d;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;
  reg_vec_t tbl[$];

  always #5 CLK_32M = ~CLK_32M;

  irq_ctrl_multi dut_a (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .ce(ce), .irq_in(irq_a),
    .cfg_we(we_a), .cfg_re(re_a), .cfg_addr(addr_a), .cfg_din(din_a), .cfg_dout(dout_a),
    .irq_rq(rq_a), .irq_vector(vec_a), .irq_ack(ack_a)
  );

  irq_ctrl_multi #(.N_IRQ(4), .AUTO_EOI(0)) dut_b (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .ce(ce), .irq_in(irq_b),
    .cfg_we(we_b), .cfg_re(re_b), .cfg_addr(addr_b), .cfg_din(din_b), .cfg_dout(dout_b),
    .irq_rq(rq_b), .irq_vector(vec_b), .irq_ack(ack_b)
  );

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mask[d] = 8'h00; m_mode[d] = 8'h00; m_vbase[d] = 8'h40;
      m_pend[d] = 8'h00; m_prev[d] = 8'h00; m_ins[d] = 8'h00;
      m_req[d] = 1'b0; m_grant[d] = 0; m_vec[d] = 0;
    end
  endtask

  // One clock of the controller rules, evaluated on the pre-edge inputs.
  task automatic model_step(input int d, input bit [7:0] iv, input bit we,
                            input bit [1:0] addr, input bit [7:0] din, input bit ack);
    int w = -1;
    bit ackf;
    bit [7:0] lim, p, ins;
    lim = 8'((1 << NCH[d]) - 1);
    for (int i = 0; i < NCH[d]; i++)
      if (w < 0 && m_pend[d][i] && !m_mask[d][i] &&
          (AUTO[d] || (m_ins[d] & 8'((2 << i) - 1)) == 0)) w = i;
    ackf = ack && m_req[d];
    p = m_pend[d];
    if (ackf && !m_mode[d][m_grant[d]]) p[m_grant[d]] = 1'b0;
    if (ce)
      for (int i = 0; i < NCH[d]; i++)
        if (m_mode[d][i]) p[i] = iv[i];
        else if (iv[i] && !m_prev[d][i]) p[i] = 1'b1;
    ins = m_ins[d];
    if (!AUTO[d]) begin
      if (we && addr == 2'd3 && ins != 0) ins = ins & (ins - 8'd1);
      if (ackf) ins[m_grant[d]] = 1'b1;
    end
    if (ackf) m_req[d] = 1'b0;
    else if (!m_req[d] && ce && w >= 0) begin
      m_req[d] = 1'b1; m_grant[d] = w;
      m_vec[d] = (m_vbase[d] * 2 + w * STRIDE) % 512;
    end
    if (ce) m_prev[d] = iv & lim;
    if (we)
      case (addr)
        2'd0: m_mask[d] = din & lim;
        2'd1: m_mode[d] = din & lim;
        2'd2: m_vbase[d] = din;
        default: ;
      endcase
    m_pend[d] = p;
    m_ins[d]  = ins;
  endtask

  task automatic apply_stimulus(input bit ce_v);
    ce = ce_v;
    if (reset_n) begin
      model_step(0, 8'(irq_a), we_a, addr_a, din_a, ack_a);
      model_step(1, 8'(irq_b), we_b, addr_b, din_b, ack_b);
    end
    @(posedge CLK_32M); #1;
    ce = 1'b0; ack_a = 1'b0; ack_b = 1'b0; we_a = 1'b0; we_b = 1'b0;
  endtask

  task automatic do_ce();
    repeat (3) apply_stimulus(1'b0);
    apply_stimulus(1'b1);
  endtask

  task automatic check_output(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int d, input logic [1:0] a, input logic [7:0] v);
    if (d == 0) begin we_a = 1'b1; addr_a = a; din_a = v; end
    else        begin we_b = 1'b1; addr_b = a; din_b = v; end
    apply_stimulus(1'b0);
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [7:0] v);
    if (d == 0) begin addr_a = a; re_a = 1'b1; #1; v = dout_a; re_a = 1'b0; end
    else        begin addr_b = a; re_b = 1'b1; #1; v = dout_b; re_b = 1'b0; end
  endtask

  task automatic ack(input int d, input bit ce_v);
    if (d == 0) ack_a = 1'b1; else ack_b = 1'b1;
    apply_stimulus(ce_v);
  endtask

  task automatic chk_pend(input int d, input string nm, input int exp);
    logic [7:0] v;
    rd(d, 2'd3, v);
    check_output(nm, int'(v), exp);
  endtask

  initial begin
    logic [7:0] v;
    reset_n = 1'b0; ce = 1'b0;
    irq_a = '0; irq_b = '0; addr_a = '0; addr_b = '0; din_a = '0; din_b = '0;
    we_a = 1'b0; we_b = 1'b0; re_a = 1'b0; re_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
    model_reset();
    repeat (3) apply_stimulus(1'b0);
    reset_n = 1'b1;

    check_output("rst_rq_a", int'(rq_a), 0);
    check_output("rst_vec_a", int'(vec_a), 0);
    check_output("rst_rq_b", int'(rq_b), 0);
    chk_pend(0, "rst_pend_a", 0);
    rd(0, 2'd0, v); check_output("rst_mask_a", int'(v), 8'h00);
    rd(0, 2'd1, v); check_output("rst_mode_a", int'(v), 8'h00);
    rd(0, 2'd2, v); check_output("rst_vbase_a", int'(v), 8'h40);

    // Register write/readback; bits above N_IRQ read back as zero
    tbl.push_back('{0, 2'd0, 8'hFF, 8'h03});
    tbl.push_back('{0, 2'd1, 8'hAA, 8'h02});
    tbl.push_back('{0, 2'd2, 8'h5A, 8'h5A});
    tbl.push_back('{0, 2'd3, 8'hFF, 8'h00});
    tbl.push_back('{0, 2'd0, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{0, 2'd2, 8'h40, 8'h40});
    tbl.push_back('{1, 2'd0, 8'hF5, 8'h05});
    tbl.push_back('{1, 2'd1, 8'h3C, 8'h0C});
    tbl.push_back('{1, 2'd2, 8'hC3, 8'hC3});
    tbl.push_back('{1, 2'd0, 8'h00, 8'h00});
    tbl.push_back('{1, 2'd1, 8'h00, 8'h00});
    tbl.push_back('{1, 2'd2, 8'h40, 8'h40});
    foreach (tbl[i]) begin
      wr(tbl[i].d, tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].d, tbl[i].addr, v);
      check_output($sformatf("reg_tbl[%0d]", i), int'(v), int'(tbl[i].exp));
    end

    // T1: single edge, one-ce request latency
    irq_a = 2'b01; do_ce();
    check_output("t1_no_rq_yet", int'(rq_a), 0);
    do_ce();
    check_output("t1_rq", int'(rq_a), 1);
    check_output("t1_vec", int'(vec_a), 'h080);
    ack(0, 1'b0);
    check_output("t1_rq_after_ack", int'(rq_a), 0);
    chk_pend(0, "t1_pend_after_ack", 0);
    irq_a = 2'b00; do_ce();

    // T2: simultaneous edges serviced in priority order
    irq_a = 2'b11; do_ce(); do_ce();
    check_output("t2_rq0", int'(rq_a), 1);
    check_output("t2_vec0", int'(vec_a), 'h080);
    ack(0, 1'b0);
    check_output("t2_rq_dropped", int'(rq_a), 0);
    chk_pend(0, "t2_pend_mid", 2'b10);
    do_ce();
    check_output("t2_rq1", int'(rq_a), 1);
    check_output("t2_vec1", int'(vec_a), 'h088);
    chk_pend(0, "t2_pend_before_ack2", 2'b10);
    ack(0, 1'b0);
    chk_pend(0, "t2_pend_end", 0);
    irq_a = 2'b00; do_ce();

    // T3: mask blocks the request but not the latch
    wr(0, 2'd0, 8'h01);
    irq_a = 2'b01; do_ce(); do_ce();
    check_output("t3_masked_rq", int'(rq_a), 0);
    chk_pend(0, "t3_masked_pend", 2'b01);
    irq_a = 2'b00;
    wr(0, 2'd0, 8'h00);
    check_output("t3_no_rq_before_ce", int'(rq_a), 0);
    do_ce();
    check_output("t3_rq", int'(rq_a), 1);
    check_output("t3_vec", int'(vec_a), 'h080);
    ack(0, 1'b0);

    // T4: in-service tracking with vector wrap
    wr(1, 2'd2, 8'hFC);
    irq_b = 4'b0100; do_ce(); do_ce();
    check_output("t4_rq_ch2", int'(rq_b), 1);
    check_output("t4_vec_ch2", int'(vec_b), 'h008);
    ack(1, 1'b0);
    irq_b = 4'b1000; do_ce(); do_ce();
    check_output("t4_ch3_blocked", int'(rq_b), 0);
    chk_pend(1, "t4_pend_ch3", 4'b1000);
    irq_b = 4'b0010; do_ce(); do_ce();
    check_output("t4_rq_ch1", int'(rq_b), 1);
    check_output("t4_vec_ch1", int'(vec_b), 'h000);
    ack(1, 1'b0);
    irq_b = 4'b0000;
    wr(1, 2'd3, 8'h00);
    do_ce();
    check_output("t4_still_blocked", int'(rq_b), 0);
    wr(1, 2'd3, 8'h00);
    do_ce();
    check_output("t4_rq_ch3", int'(rq_b), 1);
    check_output("t4_vec_ch3", int'(vec_b), 'h010);
    ack(1, 1'b0);
    wr(1, 2'd3, 8'h00);

    // T5: level channel re-requests until the source drops
    wr(0, 2'd1, 8'h02);
    irq_a = 2'b10; do_ce(); do_ce();
    check_output("t5_rq1", int'(rq_a), 1);
    check_output("t5_vec1", int'(vec_a), 'h088);
    ack(0, 1'b0);
    chk_pend(0, "t5_pend_kept", 2'b10);
    do_ce();
    check_output("t5_rq2", int'(rq_a), 1);
    check_output("t5_vec2", int'(vec_a), 'h088);
    ack(0, 1'b0);
    irq_a = 2'b00; do_ce();
    chk_pend(0, "t5_pend_cleared", 0);
    ack(0, 1'b0);
    do_ce();
    check_output("t5_no_rq", int'(rq_a), 0);
    wr(0, 2'd1, 8'h00);

    // T6: edge coincident with ack, then reset mid-request
    irq_a = 2'b01; do_ce(); do_ce();
    check_output("t6_rq", int'(rq_a), 1);
    irq_a = 2'b00; do_ce();
    irq_a = 2'b01;
    repeat (3) apply_stimulus(1'b0);
    ack(0, 1'b1);
    check_output("t6_rq_acked", int'(rq_a), 0);
    chk_pend(0, "t6_pend_edge_wins", 2'b01);
    do_ce();
    check_output("t6_rq_again", int'(rq_a), 1);
    check_output("t6_vec_again", int'(vec_a), 'h080);
    reset_n = 1'b0; #1;
    check_output("t6_rq_async_reset", int'(rq_a), 0);
    check_output("t6_vec_async_reset", int'(vec_a), 0);
    model_reset();
    irq_a = 2'b00;
    apply_stimulus(1'b0); apply_stimulus(1'b0);
    reset_n = 1'b1;
    ack(0, 1'b0);
    check_output("t6_late_ack_rq", int'(rq_a), 0);
    chk_pend(0, "t6_late_ack_pend", 0);

    // Randomized traffic against the model on both instances
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) irq_a = 2'($urandom);
      if ($urandom_range(0, 3) == 0) irq_b = 4'($urandom);
      ack_a = m_req[0] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      ack_b = m_req[1] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) begin
        we_a = 1'b1; addr_a = 2'($urandom); din_a = 8'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        we_b = 1'b1; addr_b = 2'($urandom); din_b = 8'($urandom);
      end
      apply_stimulus($urandom_range(0, 3) == 0);
      check_output("rnd_rq_a", int'(rq_a), int'(m_req[0]));
      check_output("rnd_vec_a", int'(vec_a), m_vec[0]);
      chk_pend(0, "rnd_pend_a", int'(m_pend[0]));
      check_output("rnd_rq_b", int'(rq_b), int'(m_req[1]));
      check_output("rnd_vec_b", int'(vec_b), m_vec[1]);
      chk_pend(1, "rnd_pend_b", int'(m_pend[1]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
